// File: rtl/tv_pkg.sv
// Shared TV-out constants and types for the video RAM path.
package tv_pkg;

  localparam int unsigned WORDS_PER_LINE = 32;
  localparam int unsigned ACTIVE_LINES   = 287;
  localparam int unsigned VRAM_DEPTH     = WORDS_PER_LINE * ACTIVE_LINES;
  localparam int unsigned VRAM_ADDR_W    = 14;
  localparam int unsigned VRAM_DATA_W    = 16;

  typedef enum logic {
    SRC_VID  = 1'b0,
    SRC_HOST = 1'b1
  } rd_src_t;

  // Read-return tag; zero forces the returned word to 0 (out-of-range host read).
  typedef struct packed {
    logic    valid;
    rd_src_t src;
    logic    zero;
  } rd_tag_t;

  function automatic logic vram_in_range(input int unsigned addr);
    return addr < VRAM_DEPTH;
  endfunction

endpackage

// File: rtl/tv_vram_arbiter_if.sv
// Bundle of scanout, host and RAM-side signals around the VRAM arbiter.
interface tv_vram_arbiter_if
  import tv_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_overrun;

  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side.
  modport slave (
    input  vid_req, vid_addr, host_valid, host_we, host_addr, host_wdata, ram_rdata,
    output vid_data, vid_valid, vid_overrun, host_ready, host_rdata, host_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  // Scanout, host and RAM side.
  modport master (
    output vid_req, vid_addr, host_valid, host_we, host_addr, host_wdata, ram_rdata,
    input  vid_data, vid_valid, vid_overrun, host_ready, host_rdata, host_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/tv_vram_arbiter.sv
// VRAM arbiter: scanout fetches get fixed-latency priority, host gets ready/valid access.
// Host reads exist only with TV_VRAM_HOST_READ_EN defined; otherwise every host op is a write.
module tv_vram_arbiter
  import tv_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input logic              clk,
  input logic              reset,
  tv_vram_arbiter_if.slave bus
);

  logic              vid_pend_q, vid_pend_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              vid_overrun_q, vid_overrun_d;
  logic [ADDR_W-1:0] vid_rd_addr;

  logic              host_ready_q;
  logic              host_fire;
  logic              host_is_write;
  logic              host_in_range;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              issue_vid;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;

`ifdef TV_VRAM_HOST_READ_EN
  logic              issue_host_rd;
  logic              host_rd_zero;
  assign host_is_write = bus.host_we;
`else
  logic              unused_host_we;
  assign unused_host_we = bus.host_we;
  assign host_is_write  = 1'b1;
`endif

  assign host_fire     = bus.host_valid & host_ready_q;
  assign host_in_range = vram_in_range(32'(bus.host_addr));
  // A request landing in the grant cycle merges into that read, so the newest address wins.
  assign vid_rd_addr   = bus.vid_req ? bus.vid_addr : vid_addr_q;

  // Scanout request capture; a pending request is always granted in the following cycle.
  always_comb begin
    vid_addr_d    = vid_addr_q;
    vid_pend_d    = 1'b0;
    vid_overrun_d = vid_overrun_q;
    if (bus.vid_req) begin
      vid_addr_d = bus.vid_addr;
      if (vid_pend_q) begin
        vid_overrun_d = 1'b1;
      end else begin
        vid_pend_d = 1'b1;
      end
    end
  end

  // One RAM op per cycle: video first, then an accepted host op.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    issue_vid   = 1'b0;
`ifdef TV_VRAM_HOST_READ_EN
    issue_host_rd = 1'b0;
    host_rd_zero  = 1'b0;
`endif
    if (vid_pend_q) begin
      ram_en_d   = 1'b1;
      ram_addr_d = vid_rd_addr;
      issue_vid  = 1'b1;
    end else if (host_fire && host_is_write) begin
      if (host_in_range) begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = bus.host_addr;
        ram_wdata_d = bus.host_wdata;
      end
    end
`ifdef TV_VRAM_HOST_READ_EN
    else if (host_fire) begin
      ram_en_d      = host_in_range;
      ram_addr_d    = bus.host_addr;
      issue_host_rd = 1'b1;
      host_rd_zero  = ~host_in_range;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_pend_q    <= 1'b0;
      vid_addr_q    <= '0;
      vid_overrun_q <= 1'b0;
      host_ready_q  <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
    end else begin
      vid_pend_q    <= vid_pend_d;
      vid_addr_q    <= vid_addr_d;
      vid_overrun_q <= vid_overrun_d;
      host_ready_q  <= ~vid_pend_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

`ifdef TV_VRAM_HOST_READ_EN
  rd_tag_t           tag_d, tag1_q, tag2_q;
  logic              ret_vid, ret_host;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = issue_vid | issue_host_rd;
    tag_d.src   = issue_host_rd ? SRC_HOST : SRC_VID;
    tag_d.zero  = host_rd_zero;
  end

  assign ret_vid  = tag2_q.valid && (tag2_q.src == SRC_VID);
  assign ret_host = tag2_q.valid && (tag2_q.src == SRC_HOST);

  // Stage 2 lines up with ram_rdata for the op issued two edges earlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_q        <= '0;
      tag2_q        <= '0;
      vid_valid_q   <= 1'b0;
      vid_data_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      tag1_q        <= tag_d;
      tag2_q        <= tag1_q;
      vid_valid_q   <= ret_vid;
      host_rvalid_q <= ret_host;
      if (ret_vid) begin
        vid_data_q <= bus.ram_rdata;
      end
      if (ret_host) begin
        host_rdata_q <= tag2_q.zero ? '0 : bus.ram_rdata;
      end
    end
  end

  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
`else
  logic [1:0] vid_tag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_tag_q   <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      vid_tag_q   <= {vid_tag_q[0], issue_vid};
      vid_valid_q <= vid_tag_q[1];
      if (vid_tag_q[1]) begin
        vid_data_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.host_rdata  = '0;
  assign bus.host_rvalid = 1'b0;
`endif

  assign bus.vid_data    = vid_data_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_overrun = vid_overrun_q;
  assign bus.host_ready  = host_ready_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_tv_vram_arbiter.sv
// Directed bench for tv_vram_arbiter with a behavioural VRAM and a read-return scoreboard.
module tb_tv_vram_arbiter;
  import tv_pkg::*;

`ifdef TV_VRAM_HOST_READ_EN
  localparam bit ReadEn = 1'b1;
`else
  localparam bit ReadEn = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } ret_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ret_t        vid_q[$];
  ret_t        host_q[$];
  logic [15:0] shadow[int];
  logic [15:0] mem[16384];
  bit          written[16384];

  tv_vram_arbiter_if bus ();

  tv_vram_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a) ^ 16'hC35A;
  endfunction

  function automatic logic [15:0] expect_word(input int a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  // Synchronous single-port RAM, read data valid the cycle after ram_en.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr]     <= bus.ram_wdata;
        written[bus.ram_addr] <= 1'b1;
      end
      bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr] : init_word(int'(bus.ram_addr));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return monitor: every strobe must match the head of its queue in cycle and data.
  always @(negedge clk) begin
    ret_t e;
    if (vid_q.size() > 0 && cyc > vid_q[0].cyc) begin
      e = vid_q.pop_front();
      chk("vid_valid_missing", 32'(cyc), 32'(e.cyc));
    end
    if (bus.vid_valid === 1'b1) begin
      if (vid_q.size() == 0) begin
        chk("vid_valid_spurious", 32'(bus.vid_valid), 32'd0);
      end else begin
        e = vid_q.pop_front();
        chk("vid_valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("vid_data", 32'(bus.vid_data), 32'(e.data));
      end
    end
    if (host_q.size() > 0 && cyc > host_q[0].cyc) begin
      e = host_q.pop_front();
      chk("host_rvalid_missing", 32'(cyc), 32'(e.cyc));
    end
    if (bus.host_rvalid === 1'b1) begin
      if (host_q.size() == 0) begin
        chk("host_rvalid_spurious", 32'(bus.host_rvalid), 32'd0);
      end else begin
        e = host_q.pop_front();
        chk("host_rvalid_cycle", 32'(cyc), 32'(e.cyc));
        chk("host_rdata", 32'(bus.host_rdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // One-cycle host handshake; records the expected RAM effect and any read return.
  task automatic host_op(input logic we, input int a, input logic [15:0] d, output int c);
    chk("host_ready_before_op", 32'(bus.host_ready), 32'd1);
    bus.host_valid = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = 14'(a);
    bus.host_wdata = d;
    c = cyc;
    if (!we && ReadEn) begin
      host_q.push_back('{c + 3, (a < int'(VRAM_DEPTH)) ? expect_word(a) : 16'h0000});
    end else if (a < int'(VRAM_DEPTH)) begin
      shadow[a] = d;
    end
    tick();
    bus.host_valid = 1'b0;
  endtask

  task automatic check_ram(input string tag, input int n, input logic en, input logic we,
                           input int a, input logic [15:0] d);
    at_neg(n);
    chk({tag, "_ram_en"}, 32'(bus.ram_en), 32'(en));
    chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'(we));
    if (en) chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'(a));
    if (en && we) chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'(d));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, 32'({bus.host_ready, bus.vid_valid, bus.vid_overrun,
                                bus.host_rvalid, bus.ram_en, bus.ram_we}), 32'd0);
    chk({tag, "_data"}, {bus.vid_data, bus.host_rdata}, 32'd0);
    chk({tag, "_ram_bus"}, {2'b00, bus.ram_addr, bus.ram_wdata}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int r;
    bus.vid_req    = 1'b0;
    bus.vid_addr   = '0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;

    // Reset values, then host_ready one edge after release.
    @(negedge clk);
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    r = cyc;
    at_neg(r + 1);
    chk("host_ready_after_release", 32'(bus.host_ready), 32'd1);

    // Preload 0x0021 through the host port, then a single scanout fetch.
    tick();
    host_op(1'b1, 32'h21, 16'hA5F0, c);
    check_ram("wr21", c + 1, 1'b1, 1'b1, 32'h21, 16'hA5F0);
    tick();
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h21;
    c = cyc;
    vid_q.push_back('{c + 4, expect_word(32'h21)});
    tick();
    bus.vid_req = 1'b0;
    check_ram("vid_early", c + 1, 1'b0, 1'b0, 0, 16'h0);
    check_ram("vid21", c + 2, 1'b1, 1'b0, 32'h21, 16'h0);
    at_neg(c + 5);
    chk("vid21_overrun", 32'(bus.vid_overrun), 32'd0);
    chk("vid21_returned", 32'(vid_q.size()), 32'd0);

    // Host write then host read of the same word.
    tick();
    host_op(1'b1, 32'h100, 16'h1234, c);
    check_ram("wr100", c + 1, 1'b1, 1'b1, 32'h100, 16'h1234);
    tick();
    host_op(1'b0, 32'h100, 16'h5678, c);
    check_ram("rd100", c + 1, 1'b1, !ReadEn, 32'h100, 16'h5678);
    at_neg(c + 4);
    chk("rd100_returned", 32'(host_q.size()), 32'd0);

    // Scanout request and host write in the same cycle.
    tick();
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h21;
    host_op(1'b1, 32'h200, 16'hBEEF, c);
    bus.vid_req = 1'b0;
    vid_q.push_back('{c + 4, expect_word(32'h21)});
    check_ram("both_host", c + 1, 1'b1, 1'b1, 32'h200, 16'hBEEF);
    chk("both_ready_low", 32'(bus.host_ready), 32'd0);
    check_ram("both_vid", c + 2, 1'b1, 1'b0, 32'h21, 16'h0);
    chk("both_ready_back", 32'(bus.host_ready), 32'd1);
    at_neg(c + 5);
    chk("both_returned", 32'(vid_q.size()), 32'd0);

    // Back-to-back scanout requests: one read of the newer address, sticky overrun.
    tick();
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'd5;
    c = cyc;
    vid_q.push_back('{c + 4, expect_word(6)});
    tick();
    bus.vid_addr = 14'd6;
    tick();
    bus.vid_req = 1'b0;
    check_ram("ovr_read", c + 2, 1'b1, 1'b0, 6, 16'h0);
    chk("ovr_set", 32'(bus.vid_overrun), 32'd1);
    at_neg(c + 7);
    chk("ovr_returned", 32'(vid_q.size()), 32'd0);

    // Address range boundary: last word, first word past the end, further past.
    tick();
    host_op(1'b0, 9183, 16'h7E57, c);
    check_ram("rd9183", c + 1, 1'b1, !ReadEn, 9183, 16'h7E57);
    tick();
    host_op(1'b1, 9184, 16'hDEAD, c);
    check_ram("wr9184", c + 1, 1'b0, 1'b0, 9184, 16'hDEAD);
    tick();
    host_op(1'b0, 9200, 16'h0BAD, c);
    check_ram("rd9200", c + 1, 1'b0, 1'b0, 9200, 16'h0BAD);
    at_neg(c + 4);
    chk("range_returned", 32'(host_q.size()), 32'd0);
    chk("ovr_sticky", 32'(bus.vid_overrun), 32'd1);

    // Reset between a host read handshake and its return.
    tick();
    host_op(1'b0, 32'h100, 16'h4321, c);
    reset = 1'b1;
    host_q.delete();
    at_neg(c + 1);
    check_all_zero("midreset");
    tick();
    tick();
    reset = 1'b0;
    r = cyc;
    at_neg(r + 1);
    chk("midreset_ready", 32'(bus.host_ready), 32'd1);
    at_neg(r + 5);
    chk("midreset_no_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("midreset_overrun_cleared", 32'(bus.vid_overrun), 32'd0);
    chk("final_vid_queue", 32'(vid_q.size()), 32'd0);
    chk("final_host_queue", 32'(host_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
